// File: rtl/ntt_pkg.sv
// Shared types and widths for the NTT datapath control blocks.
//   DATA_W  coefficient width seen by the core
//   ADDR_W  default core bank address width
//   LOGM_W  width of the stage index driven to the core
//   state_e sequencer states
package ntt_pkg;

    localparam int DATA_W = 30;
    localparam int ADDR_W = 9;
    localparam int LOGM_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/ntt_addr_delay.sv
// Write-back delay line: carries {valid, addr} from the read side of the core
// to its write side, DEPTH cycles later. Synchronous clear on rst_i, so an
// aborted transform leaves no write in flight.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   valid_i/addr_i read strobe and address entering the core
//   valid_o/addr_o the same, DEPTH cycles later
module ntt_addr_delay
    import ntt_pkg::*;
#(
    parameter int DEPTH  = 6,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]             vld_pipe_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_pipe_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe_q  <= '0;
            addr_pipe_q <= '0;
        end else begin
            vld_pipe_q[0]  <= valid_i;
            addr_pipe_q[0] <= addr_i;
            for (int k = 1; k < DEPTH; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                addr_pipe_q[k] <= addr_pipe_q[k-1];
            end
        end
    end

    assign valid_o = vld_pipe_q[DEPTH-1];
    assign addr_o  = addr_pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Stage sequencer for ntt_core: walks one transform through all LOG_N
// butterfly stages (forward: log_m ascending, inverse: descending). Each stage
// issues ITER reads, then idles CORE_LAT cycles so the last write-back lands
// before the next stage reads.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, inverse_i      begin request (IDLE only) and its direction
//   busy_o, done_o          in-progress flag, one-cycle completion pulse
//   log_m_o, i_o            stage index and butterfly group index
//   read_address_o, mode_o  core read address, latched direction
//   write_enable_o, upper/lower_write_address_o  write-back, CORE_LAT later
//   cycle_count_o           busy-cycle counter (only with NTT_SEQ_STATS_EN)
// Optional feature macro: NTT_SEQ_STATS_EN
module ntt_stage_sequencer
    import ntt_pkg::*;
#(
    parameter int LOG_N    = 10,
    parameter int ADDR_W   = 9,
    parameter int ITER     = 256,
    parameter int CORE_LAT = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              inverse_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LOGM_W-1:0] log_m_o,
    output logic [ADDR_W-1:0] i_o,
    output logic [ADDR_W-1:0] read_address_o,
    output logic              mode_o,
    output logic              write_enable_o,
    output logic [ADDR_W-1:0] upper_write_address_o,
    output logic [ADDR_W-1:0] lower_write_address_o
`ifdef NTT_SEQ_STATS_EN
    ,
    output logic [31:0]       cycle_count_o
`endif
);

    localparam int DR_W = $clog2(CORE_LAT + 1);
    localparam logic [ADDR_W-1:0] CNT_LAST   = ADDR_W'(ITER - 1);
    localparam logic [LOGM_W-1:0] LOGM_LAST  = LOGM_W'(LOG_N - 1);
    localparam logic [DR_W-1:0]   DRAIN_LAST = DR_W'(CORE_LAT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [LOGM_W-1:0] log_m_q, log_m_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic              mode_q, mode_d;
    logic              last_stage;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;

    // Final stage depends on direction: log_m ends at 0 going inverse.
    assign last_stage = mode_q ? (log_m_q == '0) : (log_m_q == LOGM_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            log_m_q <= '0;
            drain_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            log_m_q <= log_m_d;
            drain_q <= drain_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        log_m_d = log_m_q;
        drain_d = drain_q;
        mode_d  = mode_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    mode_d  = inverse_i;
                    cnt_d   = '0;
                    log_m_d = inverse_i ? LOGM_LAST : '0;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                // cnt/log_m hold here so the core sees stable indices.
                busy_o = 1'b1;
                if (drain_q == DRAIN_LAST) begin
                    if (last_stage) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                        log_m_d = mode_q ? log_m_q - 1'b1 : log_m_q + 1'b1;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign log_m_o        = log_m_q;
    assign i_o            = cnt_q;
    assign read_address_o = cnt_q;
    assign mode_o         = mode_q;

    ntt_addr_delay #(
        .DEPTH  (CORE_LAT),
        .ADDR_W (ADDR_W)
    ) u_wb_delay (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (state_q == RUN),
        .addr_i  (cnt_q),
        .valid_o (wb_valid),
        .addr_o  (wb_addr)
    );

    assign write_enable_o        = wb_valid;
    assign upper_write_address_o = wb_addr;
    assign lower_write_address_o = wb_addr;

`ifdef NTT_SEQ_STATS_EN
    logic [31:0] cyc_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            cyc_cnt_q <= '0;
        end else if (busy_o && cyc_cnt_q != 32'hFFFF_FFFF) begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign cycle_count_o = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer (LOG_N=4, ITER=4, CORE_LAT=3). A timeline
// model (cycle offset since start -> stage/offset by division) is compared
// against the DUT every cycle; directed runs pin the model with literals.
module tb_ntt_stage_sequencer;

    localparam int LOG_N = 4;
    localparam int ITER  = 4;
    localparam int LAT   = 3;
    localparam int AW    = 9;
    localparam int TOTAL = LOG_N * (ITER + LAT);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          inverse = 1'b0;
    logic          busy, done, mode, we;
    logic [3:0]    log_m;
    logic [AW-1:0] i_idx, read_address, wa_up, wa_lo;
`ifdef NTT_SEQ_STATS_EN
    logic [31:0]   cycle_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ntt_stage_sequencer #(
        .LOG_N(LOG_N), .ADDR_W(AW), .ITER(ITER), .CORE_LAT(LAT)
    ) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .start_i               (start),
        .inverse_i             (inverse),
        .busy_o                (busy),
        .done_o                (done),
        .log_m_o               (log_m),
        .i_o                   (i_idx),
        .read_address_o        (read_address),
        .mode_o                (mode),
        .write_enable_o        (we),
        .upper_write_address_o (wa_up),
        .lower_write_address_o (wa_lo)
`ifdef NTT_SEQ_STATS_EN
        ,
        .cycle_count_o         (cycle_count)
`endif
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit m_valid = 0, m_active = 0, m_zero = 0, m_mode = 0;
    int m_t = 0, m_cc = 0, cyc = 0;
    bit rd_v [8192];
    int rd_a [8192];

    initial begin
        int s, off, e_logm, e_addr, e_we, e_wa;
        bit e_busy, e_done;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e_busy = m_active && (m_t < TOTAL);
                e_done = m_active && (m_t == TOTAL);
                rd_v[cyc] = 1'b0;
                e_logm = 0;
                e_addr = 0;
                if (e_busy) begin
                    s      = m_t / (ITER + LAT);
                    off    = m_t % (ITER + LAT);
                    e_logm = m_mode ? (LOG_N - 1 - s) : s;
                    e_addr = (off < ITER) ? off : ITER - 1;
                    rd_v[cyc] = (off < ITER);
                    rd_a[cyc] = e_addr;
                end
                e_we = (cyc >= LAT) ? int'(rd_v[cyc-LAT]) : 0;
                e_wa = (cyc >= LAT) ? rd_a[cyc-LAT] : 0;
                chk("busy", int'(busy), int'(e_busy));
                chk("done", int'(done), int'(e_done));
                chk("write_enable", int'(we), e_we);
                chk("mode", int'(mode), int'(m_mode));
                if (e_we) begin
                    chk("upper_wr_addr", int'(wa_up), e_wa);
                    chk("lower_wr_addr", int'(wa_lo), e_wa);
                end
                if (e_busy || m_zero) begin
                    chk("log_m", int'(log_m), e_logm);
                    chk("i", int'(i_idx), e_addr);
                    chk("read_address", int'(read_address), e_addr);
                end
                if (m_zero) begin
                    chk("upper_wr_addr_rst", int'(wa_up), 0);
                    chk("lower_wr_addr_rst", int'(wa_lo), 0);
                end
`ifdef NTT_SEQ_STATS_EN
                chk("cycle_count", int'(cycle_count), m_cc);
`endif
            end
            // advance to the state after the coming rising edge
            if (rst) begin
                for (int k = cyc - LAT + 1; k <= cyc; k++)
                    if (k >= 0) rd_v[k] = 1'b0;
                m_valid  = 1;
                m_active = 0;
                m_t      = 0;
                m_zero   = 1;
                m_mode   = 0;
                m_cc     = 0;
            end else if (m_valid) begin
                if (m_active) begin
                    if (m_t < TOTAL) m_cc++;
                    m_t++;
                    if (m_t > TOTAL) m_active = 0;
                end else if (start) begin
                    m_active = 1;
                    m_t      = 0;
                    m_mode   = inverse;
                    m_zero   = 0;
                    m_cc     = 0;
                end
            end
            cyc++;
        end
    end

    // ---------------- directed runs with literal expectations ----------------
    task automatic run_case(input bit inv, input int s1, input int s2,
                            input int rst_at, input int exp_busy, input int exp_done);
        int nb, nd;
        nb = 0;
        nd = 0;
        start   = 1'b1;
        inverse = inv;
        tick();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy) nb++;
            if (done) nd++;
            if (rst_at < 0) begin
                if (k == 0) chk("first_log_m", int'(log_m), inv ? 3 : 0);
                if (k == 2) chk("rd_addr_k2", int'(read_address), 2);
                if (k == 5) begin
                    chk("we_k5", int'(we), 1);
                    chk("wa_k5", int'(wa_up), 2);
                end
                if (k == 27) chk("last_log_m", int'(log_m), inv ? 0 : 3);
                if (k == 28) chk("done_k28", int'(done), 1);
            end else if (k == rst_at + 1) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_log_m", int'(log_m), 0);
                chk("rst_rd_addr", int'(read_address), 0);
                chk("rst_mode", int'(mode), 0);
            end
            if (rst_at >= 0 && k > rst_at) chk("we_after_rst", int'(we), 0);
            start = (k == s1) || (k == s2);
            rst   = (k == rst_at);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
        chk("busy_cycles", nb, exp_busy);
        chk("done_pulses", nd, exp_done);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();
        run_case(1'b0, -1, -1, -1, TOTAL, 1);   // forward
        run_case(1'b1, -1, -1, -1, TOTAL, 1);   // inverse
        run_case(1'b0,  5, 28, -1, TOTAL, 1);   // start while busy / in DONE
        run_case(1'b1, -1, -1, 10, 11, 0);      // reset mid-run
        run_case(1'b0, -1, -1, -1, TOTAL, 1);   // full run after abort
        for (int n = 0; n < 1500; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 24) == 0);
            inverse = $urandom_range(0, 1);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (40) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
